// File: rtl/fnd_pkg.sv
// Shared definitions for 7-segment scan decoding: active-low segment codes, slot
// classes, FSM states and the digit-enable to position mapping.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_DOT   = 8'h7F;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {ClsDigit, ClsDotOn, ClsBlank, ClsInvalid} slot_class_e;

  typedef enum logic [1:0] {StIdle, StCollect, StPublish} scan_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] pos;
  } com_pos_t;

  // Digit enables are active-low one-hot; the index of the single zero is the position.
  function automatic com_pos_t com_to_pos(input logic [3:0] com);
    com_pos_t res;
    res.valid = 1'b1;
    res.pos   = 2'd0;
    case (com)
      4'b1110: res.pos = 2'd0;
      4'b1101: res.pos = 2'd1;
      4'b1011: res.pos = 2'd2;
      4'b0111: res.pos = 2'd3;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// Multiplexed 7-segment scan bus: the display controller drives it, decoders observe it.
interface fnd_scan_decoder_if;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  modport master (output fnd_com, output fnd_data);
  modport slave  (input fnd_com, input fnd_data);
endinterface

// File: rtl/fnd_seg_decoder.sv
// Classifies one scan slot (digit enables + segment pattern) into digit, dot, blank or invalid.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0]  i_com,
  input  logic [7:0]  i_data,
  output slot_class_e o_class,
  output logic [1:0]  o_pos,
  output logic [3:0]  o_value
);

  com_pos_t w_com_pos;

  always_comb begin
    w_com_pos = com_to_pos(i_com);
    o_pos     = w_com_pos.pos;
    o_class   = ClsDigit;
    o_value   = 4'h0;
    case (i_data)
      SEG_0:     o_value = 4'h0;
      SEG_1:     o_value = 4'h1;
      SEG_2:     o_value = 4'h2;
      SEG_3:     o_value = 4'h3;
      SEG_4:     o_value = 4'h4;
      SEG_5:     o_value = 4'h5;
      SEG_6:     o_value = 4'h6;
      SEG_7:     o_value = 4'h7;
      SEG_8:     o_value = 4'h8;
      SEG_9:     o_value = 4'h9;
      SEG_A:     o_value = 4'hA;
      SEG_B:     o_value = 4'hB;
      SEG_C:     o_value = 4'hC;
      SEG_D:     o_value = 4'hD;
      SEG_DOT:   o_class = ClsDotOn;
      SEG_BLANK: o_class = ClsBlank;
      default:   o_class = ClsInvalid;
    endcase
    if (!w_com_pos.valid) begin
      o_class = ClsInvalid;
    end
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Reconstructs the displayed 4-digit value and dot mask from the scan bus, one 8-slot
// frame at a time, with slot stability qualification and a staleness timeout.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  fnd_scan_decoder_if.slave   i_scan,
  output logic [15:0]         o_digits,
  output logic [3:0]          o_dots,
  output logic                o_valid,
  output logic                o_err,
  output logic                o_stale
);

  localparam int unsigned STAB_W = $clog2(SETTLE_CYCLES);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(SETTLE_CYCLES - 2);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [11:0]       r_sync [SYNC_STAGES];
  logic [11:0]       r_prev;
  logic [STAB_W-1:0] r_stab;
  logic [IDLE_W-1:0] r_idle;
  logic [11:0]       w_pair;
  logic              w_same;
  logic              w_accept;
  logic              w_timeout;
  logic [STAB_W-1:0] w_stab_d;
  logic [IDLE_W-1:0] w_idle_d;

  slot_class_e w_class;
  logic [1:0]  w_pos;
  logic [3:0]  w_value;

  scan_state_e      r_state, w_state_d;
  logic [2:0]       r_cnt, w_cnt_d;
  logic [3:0][3:0]  r_sh_digit, w_sh_digit_d;
  logic [3:0]       r_sh_dot, w_sh_dot_d;
  logic [3:0]       r_seen, w_seen_d;
  logic             r_ferr, w_ferr_d;
  logic [15:0]      r_digits, w_digits_d;
  logic [3:0]       r_dots, w_dots_d;
  logic             r_valid, w_valid_d;
  logic             r_err, w_err_d;
  logic             r_stale, w_stale_d;
  logic             w_clear;
  logic             w_apply;

  // Synchronizer resets to all ones, which is the idle (all-off) bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
    end else begin
      r_sync[0] <= {i_scan.fnd_com, i_scan.fnd_data};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_pair = r_sync[SYNC_STAGES-1];

  // Acceptance fires on the one cycle the counter steps to its saturation value.
  always_comb begin
    w_same    = (w_pair == r_prev);
    w_accept  = w_same && (r_stab == STAB_PRE);
    w_stab_d  = r_stab;
    if (!w_same) begin
      w_stab_d = '0;
    end else if (r_stab != STAB_MAX) begin
      w_stab_d = r_stab + 1'b1;
    end
    w_timeout = !w_accept && (r_idle == IDLE_PRE);
    w_idle_d  = r_idle;
    if (w_accept) begin
      w_idle_d = '0;
    end else if (r_idle != IDLE_MAX) begin
      w_idle_d = r_idle + 1'b1;
    end
  end

  fnd_seg_decoder u_seg_decoder (
    .i_com   (w_pair[11:8]),
    .i_data  (w_pair[7:0]),
    .o_class (w_class),
    .o_pos   (w_pos),
    .o_value (w_value)
  );

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_sh_digit_d = r_sh_digit;
    w_sh_dot_d   = r_sh_dot;
    w_seen_d     = r_seen;
    w_ferr_d     = r_ferr;
    w_digits_d   = r_digits;
    w_dots_d     = r_dots;
    w_valid_d    = 1'b0;
    w_err_d      = 1'b0;
    w_stale_d    = r_stale;
    w_clear      = 1'b0;
    w_apply      = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_apply   = 1'b1;
          w_state_d = StCollect;
        end
      end
      StCollect: begin
        if (w_accept) begin
          w_apply = 1'b1;
          if (r_cnt == 3'd7) w_state_d = StPublish;
        end
      end
      StPublish: begin
        if (!r_ferr && (&r_seen)) begin
          w_digits_d = r_sh_digit;
          w_dots_d   = r_sh_dot;
          w_valid_d  = 1'b1;
          w_stale_d  = 1'b0;
        end else begin
          w_err_d = 1'b1;
        end
        w_clear   = 1'b1;
        w_apply   = w_accept;
        w_state_d = StCollect;
      end
      default: w_state_d = StIdle;
    endcase

    if (w_timeout) begin
      w_state_d = StIdle;
      w_clear   = 1'b1;
      w_stale_d = 1'b1;
    end

    if (w_clear) begin
      w_cnt_d      = '0;
      w_sh_digit_d = '0;
      w_sh_dot_d   = '0;
      w_seen_d     = '0;
      w_ferr_d     = 1'b0;
    end

    // Applied after the clear so a slot landing in the publish cycle opens the next frame.
    if (w_apply) begin
      case (w_class)
        ClsDigit: begin
          w_sh_digit_d[w_pos] = w_value;
          w_seen_d[w_pos]     = 1'b1;
        end
        ClsDotOn: w_sh_dot_d[w_pos] = 1'b1;
        ClsBlank: ;
        default:  w_ferr_d = 1'b1;
      endcase
      if (w_cnt_d != 3'd7) w_cnt_d = w_cnt_d + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev     <= '1;
      r_stab     <= '0;
      r_idle     <= '0;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_sh_digit <= '0;
      r_sh_dot   <= '0;
      r_seen     <= '0;
      r_ferr     <= 1'b0;
      r_digits   <= '0;
      r_dots     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_stale    <= 1'b1;
    end else begin
      r_prev     <= w_pair;
      r_stab     <= w_stab_d;
      r_idle     <= w_idle_d;
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_sh_digit <= w_sh_digit_d;
      r_sh_dot   <= w_sh_dot_d;
      r_seen     <= w_seen_d;
      r_ferr     <= w_ferr_d;
      r_digits   <= w_digits_d;
      r_dots     <= w_dots_d;
      r_valid    <= w_valid_d;
      r_err      <= w_err_d;
      r_stale    <= w_stale_d;
    end
  end

  assign o_digits = r_digits;
  assign o_dots   = r_dots;
  assign o_valid  = r_valid;
  assign o_err    = r_err;
  assign o_stale  = r_stale;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: frames, glitches, bad codes, timeout and reset.
module tb_fnd_scan_decoder;

  localparam int unsigned SYNC    = 2;
  localparam int unsigned SETTLE  = 6;
  localparam int unsigned TIMEOUT = 300;
  localparam int          SLOT    = 12;

  typedef logic [0:7][7:0] data8_t;
  typedef logic [0:7][1:0] pos8_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] o_digits;
  logic [3:0]  o_dots;
  logic        o_valid;
  logic        o_err;
  logic        o_stale;

  int vectors     = 0;
  int miscompares = 0;
  int n_valid     = 0;
  int n_err       = 0;
  int v0, e0;

  fnd_scan_decoder_if bus ();

  fnd_scan_decoder #(
    .SYNC_STAGES    (SYNC),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_scan   (bus),
    .o_digits (o_digits),
    .o_dots   (o_dots),
    .o_valid  (o_valid),
    .o_err    (o_err),
    .o_stale  (o_stale)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a stuck pulse shows up as more than one.
  always @(posedge clk) begin
    #1;
    if (o_valid === 1'b1) n_valid++;
    if (o_err === 1'b1) n_err++;
  end

  function automatic logic [7:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic data8_t std_frame(input logic [15:0] digits, input logic [3:0] dots);
    data8_t d;
    for (int i = 0; i < 4; i++) begin
      d[i]   = seg(digits[4*i +: 4]);
      d[i+4] = dots[i] ? 8'h7F : 8'hFF;
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic [1:0] pos, input logic [7:0] data, input int cycles);
    logic [3:0] one;
    one          = 4'b0001;
    bus.fnd_com  = ~(one << pos);
    bus.fnd_data = data;
    repeat (cycles) @(negedge clk);
  endtask

  // glitch_at >= 0 inserts a too-short 8'h55 pair ahead of that slot.
  task automatic send8(input pos8_t p, input data8_t d, input int glitch_at);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_at) slot(p[i], 8'h55, SETTLE - 1);
      slot(p[i], d[i], SLOT);
    end
  endtask

  task automatic frame_result(input string tag, input int exp_valid, input int exp_err,
                              input logic [15:0] exp_digits, input logic [3:0] exp_dots,
                              input logic exp_stale);
    check({tag, "_valid"}, n_valid - v0, exp_valid);
    check({tag, "_err"}, n_err - e0, exp_err);
    check({tag, "_digits"}, o_digits, exp_digits);
    check({tag, "_dots"}, o_dots, exp_dots);
    check({tag, "_stale"}, o_stale, exp_stale);
  endtask

  initial begin
    pos8_t  p_std, p_miss, p_rep;
    data8_t d;
    p_std  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    p_miss = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    p_rep  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd1, 2'd3};

    rst          = 1'b0;
    bus.fnd_com  = 4'b1110;
    bus.fnd_data = seg(4'h4);
    repeat (3) @(negedge clk);
    check("rst_digits", o_digits, 16'h0000);
    check("rst_dots", o_dots, 4'h0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_stale", o_stale, 1'b1);
    rst = 1'b1;

    // Nominal: 1234 with the hundreds dot lit
    v0 = n_valid; e0 = n_err;
    send8(p_std, std_frame(16'h1234, 4'b0100), -1);
    frame_result("nominal", 1, 0, 16'h1234, 4'b0100, 1'b0);

    // Short glitch ahead of slot 2 must not be taken as a slot
    v0 = n_valid; e0 = n_err;
    send8(p_std, std_frame(16'h1234, 4'b0100), 2);
    frame_result("glitch", 1, 0, 16'h1234, 4'b0100, 1'b0);

    // Unknown segment code in one digit slot
    v0 = n_valid; e0 = n_err;
    d = std_frame(16'h1234, 4'b0000);
    d[1] = 8'h55;
    send8(p_std, d, -1);
    frame_result("badcode", 0, 1, 16'h1234, 4'b0100, 1'b0);

    // Eight slots that never visit the thousands position
    v0 = n_valid; e0 = n_err;
    d = '{seg(4'h4), seg(4'h3), seg(4'h2), 8'hFF, 8'hFF, 8'hFF, seg(4'h5), seg(4'h6)};
    send8(p_miss, d, -1);
    frame_result("missing", 0, 1, 16'h1234, 4'b0100, 1'b0);

    // Scan freezes after three slots
    v0 = n_valid; e0 = n_err;
    slot(2'd0, seg(4'h5), SLOT);
    slot(2'd1, seg(4'h0), SLOT);
    slot(2'd2, seg(4'h9), SLOT);
    repeat (240) @(negedge clk);
    check("pre_timeout_stale", o_stale, 1'b0);
    repeat (100) @(negedge clk);
    check("timeout_stale", o_stale, 1'b1);
    check("timeout_err", n_err - e0, 0);
    check("timeout_digits", o_digits, 16'h1234);

    v0 = n_valid; e0 = n_err;
    send8(p_std, std_frame(16'h0905, 4'b0000), -1);
    frame_result("resume", 1, 0, 16'h0905, 4'b0000, 1'b0);

    // Reset after five slots of a frame
    d = std_frame(16'h5678, 4'b1111);
    for (int i = 0; i < 5; i++) slot(p_std[i], d[i], SLOT);
    rst = 1'b0;
    #1;
    check("midrst_digits", o_digits, 16'h0000);
    check("midrst_dots", o_dots, 4'h0);
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_err", o_err, 1'b0);
    check("midrst_stale", o_stale, 1'b1);
    bus.fnd_com  = 4'b1110;
    bus.fnd_data = seg(4'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Thousands position repeated inside the frame: last digit wins
    v0 = n_valid; e0 = n_err;
    d = '{seg(4'h1), seg(4'h2), seg(4'h3), seg(4'h4), 8'h7F, seg(4'h9), 8'hFF, 8'h7F};
    send8(p_rep, d, -1);
    frame_result("postrst", 1, 0, 16'h9321, 4'b1001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
